ps2_kbd_matrix: RTL and testbench

- Parametrised successor PS/2 keyboard front-end for the retro-machine cores.
- Receives PS/2 set-2 frames with a filtered clock and a frame watchdog.
- Decodes E0/F0/E1 prefix sequences, maps keys through a replaceable keymap, and maintains a ROWS x COLS key matrix.
- The CPU-side keyboard port reads the matrix by row-select vector; modifier and hotkey outputs feed the reset and shift logic.

---
 rtl/ps2_kbd_pkg.sv | 50 +++++
 rtl/ps2_keymap.sv | 85 ++++++++
 rtl/ps2_kbd_matrix.sv | 239 +++++++++++++++++++++++
 tb/tb_ps2_kbd_matrix.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbd_pkg
// Description : Shared constants and types for the PS/2 keyboard matrix
//               front-end: set-2 prefix codes, modifier codes, prefix FSM
//               state encoding and the keymap result record.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_kbd_pkg;

    // Set-2 prefix and special codes
    localparam logic [7:0] PFX_E0    = 8'hE0;
    localparam logic [7:0] PFX_F0    = 8'hF0;
    localparam logic [7:0] PFX_E1    = 8'hE1;
    localparam logic [7:0] OVR_00    = 8'h00;
    localparam logic [7:0] OVR_FF    = 8'hFF;
    localparam logic [7:0] MC_ALT    = 8'h11;
    localparam logic [7:0] MC_CTRL   = 8'h14;
    localparam logic [7:0] MC_LSHIFT = 8'h12;
    localparam logic [7:0] MC_RSHIFT = 8'h59;
    localparam logic [7:0] KC_F11    = 8'h78;

    // Bytes following E1 in the Pause sequence (E1 14 77 E1 F0 14 F0 77)
    localparam logic [2:0] SKIP_LEN  = 3'd7;

    // Prefix FSM state encoding
    typedef logic [2:0] pfx_state_t;
    localparam pfx_state_t ST_IDLE   = 3'd0;
    localparam pfx_state_t ST_EXT    = 3'd1;
    localparam pfx_state_t ST_BRK    = 3'd2;
    localparam pfx_state_t ST_EXTBRK = 3'd3;
    localparam pfx_state_t ST_SKIP   = 3'd4;

    // Keymap result: matrix cell for a scancode
    typedef struct packed {
        logic       hit;
        logic [3:0] row;
        logic [2:0] col;
    } kmap_t;

    function automatic kmap_t mk(input logic [3:0] row, input logic [2:0] col);
        kmap_t m;
        m.hit = 1'b1;
        m.row = row;
        m.col = col;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_keymap.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keymap
// Description : Combinational scancode -> matrix cell map (86RK-style 8x8
//               layout plus modifier row 8). Replace this file to retarget
//               the front-end to another machine.
// Revision    : 1.0 - initial release
// Ports       : ext  - code was preceded by E0
//               code - set-2 scancode
//               map  - {hit, row, col}; hit=0 for unmapped codes
// ============================================================================
module ps2_keymap
    import ps2_kbd_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output kmap_t      map
);

    always_comb begin
        map = '0;
        if (ext) begin
            // Extended arrows share cells with the keypad arrows
            case (code)
                8'h5A: map = mk(4'd0, 3'd2);
                8'h6B: map = mk(4'd0, 3'd4);
                8'h75: map = mk(4'd0, 3'd5);
                8'h74: map = mk(4'd0, 3'd6);
                8'h72: map = mk(4'd0, 3'd7);
                8'h14: map = mk(4'd8, 3'd1);
                8'h11: map = mk(4'd8, 3'd2);
                default: map = '0;
            endcase
        end else begin
            case (code)
                // row 0: tab, lf, cr, bs, left, up, right, down
                8'h0D: map = mk(4'd0, 3'd0);  8'h69: map = mk(4'd0, 3'd1);
                8'h5A: map = mk(4'd0, 3'd2);  8'h66: map = mk(4'd0, 3'd3);
                8'h6B: map = mk(4'd0, 3'd4);  8'h75: map = mk(4'd0, 3'd5);
                8'h74: map = mk(4'd0, 3'd6);  8'h72: map = mk(4'd0, 3'd7);
                // row 1: 0..7
                8'h45: map = mk(4'd1, 3'd0);  8'h16: map = mk(4'd1, 3'd1);
                8'h1E: map = mk(4'd1, 3'd2);  8'h26: map = mk(4'd1, 3'd3);
                8'h25: map = mk(4'd1, 3'd4);  8'h2E: map = mk(4'd1, 3'd5);
                8'h36: map = mk(4'd1, 3'd6);  8'h3D: map = mk(4'd1, 3'd7);
                // row 2: 8 9 ' ; , - . /
                8'h3E: map = mk(4'd2, 3'd0);  8'h46: map = mk(4'd2, 3'd1);
                8'h52: map = mk(4'd2, 3'd2);  8'h4C: map = mk(4'd2, 3'd3);
                8'h41: map = mk(4'd2, 3'd4);  8'h4E: map = mk(4'd2, 3'd5);
                8'h49: map = mk(4'd2, 3'd6);  8'h4A: map = mk(4'd2, 3'd7);
                // row 3: [ ] \ = space ` esc F1
                8'h54: map = mk(4'd3, 3'd0);  8'h5B: map = mk(4'd3, 3'd1);
                8'h5D: map = mk(4'd3, 3'd2);  8'h55: map = mk(4'd3, 3'd3);
                8'h29: map = mk(4'd3, 3'd4);  8'h0E: map = mk(4'd3, 3'd5);
                8'h76: map = mk(4'd3, 3'd6);  8'h05: map = mk(4'd3, 3'd7);
                // row 4: F2 A B C D E F G
                8'h06: map = mk(4'd4, 3'd0);  8'h1C: map = mk(4'd4, 3'd1);
                8'h32: map = mk(4'd4, 3'd2);  8'h21: map = mk(4'd4, 3'd3);
                8'h23: map = mk(4'd4, 3'd4);  8'h24: map = mk(4'd4, 3'd5);
                8'h2B: map = mk(4'd4, 3'd6);  8'h34: map = mk(4'd4, 3'd7);
                // row 5: H I J K L M N O
                8'h33: map = mk(4'd5, 3'd0);  8'h43: map = mk(4'd5, 3'd1);
                8'h3B: map = mk(4'd5, 3'd2);  8'h42: map = mk(4'd5, 3'd3);
                8'h4B: map = mk(4'd5, 3'd4);  8'h3A: map = mk(4'd5, 3'd5);
                8'h31: map = mk(4'd5, 3'd6);  8'h44: map = mk(4'd5, 3'd7);
                // row 6: P Q R S T U V W
                8'h4D: map = mk(4'd6, 3'd0);  8'h15: map = mk(4'd6, 3'd1);
                8'h2D: map = mk(4'd6, 3'd2);  8'h1B: map = mk(4'd6, 3'd3);
                8'h2C: map = mk(4'd6, 3'd4);  8'h3C: map = mk(4'd6, 3'd5);
                8'h2A: map = mk(4'd6, 3'd6);  8'h1D: map = mk(4'd6, 3'd7);
                // row 7: X Y Z F3 F4 F5 F6 F7
                8'h22: map = mk(4'd7, 3'd0);  8'h35: map = mk(4'd7, 3'd1);
                8'h1A: map = mk(4'd7, 3'd2);  8'h04: map = mk(4'd7, 3'd3);
                8'h0C: map = mk(4'd7, 3'd4);  8'h03: map = mk(4'd7, 3'd5);
                8'h0B: map = mk(4'd7, 3'd6);  8'h83: map = mk(4'd7, 3'd7);
                // row 8: modifiers
                8'h12: map = mk(4'd8, 3'd0);  8'h59: map = mk(4'd8, 3'd0);
                8'h14: map = mk(4'd8, 3'd1);  8'h11: map = mk(4'd8, 3'd2);
                default: map = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_matrix.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbd_matrix
// Description : PS/2 set-2 keyboard front-end: filtered clock, frame receive
//               with watchdog, E0/F0/E1 prefix decode, keymap lookup and a
//               ROWS x COLS key matrix read by row-select vector.
// Revision    : 1.0 - initial release
// Ports       : clk, reset_n (async, active-low)
//               ps2_clk, ps2_dat - raw asynchronous PS/2 lines
//               addr      - active-high row select (SCAN_ROWS bits)
//               odata     - OR of selected rows (combinational)
//               mods      - {alt, ctrl, shift} live state
//               reset_key - registered F11 hotkey code
//               frame_err - pulse on bad frame or watchdog timeout
//               key_evt   - pulse when a mapped key changes state
// ============================================================================
module ps2_kbd_matrix
    import ps2_kbd_pkg::*;
#(
    parameter int ROWS      = 11,
    parameter int COLS      = 8,
    parameter int SCAN_ROWS = 8,
    parameter int FILT      = 4,
    parameter int TIMEOUT   = 20000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ps2_clk,
    input  logic                 ps2_dat,
    input  logic [SCAN_ROWS-1:0] addr,
    output logic [COLS-1:0]      odata,
    output logic [2:0]           mods,
    output logic [2:0]           reset_key,
    output logic                 frame_err,
    output logic                 key_evt
);

    localparam int FC_W = $clog2(FILT + 1);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic            clk_s1, clk_s2, dat_s1, dat_s2;
    logic            filt_lvl;
    logic [FC_W-1:0] filt_cnt;
    logic            edge_acc;
    logic [3:0]      bit_cnt;
    logic [9:0]      shreg;
    logic [WD_W-1:0] wd_cnt;
    logic [7:0]      byte_reg;
    logic            byte_stb;
    pfx_state_t      state, nxt_state;
    logic [2:0]      skip_cnt, nxt_skip;
    logic            ev_valid, ev_make, ev_ext, overrun;
    logic            alt_l, alt_r, ctrl_l, ctrl_r, shift_l, shift_r;
    logic [COLS-1:0] keystate [ROWS];
    kmap_t           km;
    logic            frame_ok;

    // Debounced level: flips after FILT consecutive samples of the opposite
    // value. A 1->0 flip is the accepted falling edge.
    assign edge_acc = filt_lvl && !clk_s2 && (filt_cnt == FC_W'(FILT - 1));

    // Start bit sits in shreg[0], parity in shreg[9]; stop is the live bit.
    assign frame_ok = !shreg[0] && (^shreg[9:1]) && dat_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1    <= 1'b1;
            clk_s2    <= 1'b1;
            dat_s1    <= 1'b1;
            dat_s2    <= 1'b1;
            filt_lvl  <= 1'b1;
            filt_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            wd_cnt    <= '0;
            byte_reg  <= '0;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            clk_s1    <= ps2_clk;
            clk_s2    <= clk_s1;
            dat_s1    <= ps2_dat;
            dat_s2    <= dat_s1;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;

            if (clk_s2 == filt_lvl) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FC_W'(FILT - 1)) begin
                filt_cnt <= '0;
                filt_lvl <= clk_s2;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end

            if (edge_acc) begin
                wd_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (frame_ok) begin
                        byte_reg <= shreg[8:1];
                        byte_stb <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                    shreg   <= {dat_s2, shreg[9:1]};
                end
            end else if (bit_cnt != 4'd0) begin
                if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    wd_cnt    <= '0;
                    bit_cnt   <= '0;
                    frame_err <= 1'b1;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    // Prefix decode: turns each byte strobe into at most one make/break event
    always_comb begin
        nxt_state = state;
        nxt_skip  = skip_cnt;
        ev_valid  = 1'b0;
        ev_make   = 1'b0;
        ev_ext    = 1'b0;
        overrun   = 1'b0;
        if (byte_stb) begin
            case (state)
                ST_IDLE: begin
                    if (byte_reg == PFX_E0) begin
                        nxt_state = ST_EXT;
                    end else if (byte_reg == PFX_F0) begin
                        nxt_state = ST_BRK;
                    end else if (byte_reg == PFX_E1) begin
                        nxt_state = ST_SKIP;
                        nxt_skip  = SKIP_LEN;
                    end else if (byte_reg == OVR_00 || byte_reg == OVR_FF) begin
                        overrun = 1'b1;
                    end else begin
                        ev_valid = 1'b1;
                        ev_make  = 1'b1;
                    end
                end
                ST_EXT: begin
                    nxt_state = ST_IDLE;
                    if (byte_reg == PFX_F0) begin
                        nxt_state = ST_EXTBRK;
                    end else if (byte_reg != MC_LSHIFT && byte_reg != MC_RSHIFT) begin
                        ev_valid = 1'b1;
                        ev_make  = 1'b1;
                        ev_ext   = 1'b1;
                    end
                end
                ST_BRK: begin
                    nxt_state = ST_IDLE;
                    ev_valid  = 1'b1;
                end
                ST_EXTBRK: begin
                    nxt_state = ST_IDLE;
                    if (byte_reg != MC_LSHIFT && byte_reg != MC_RSHIFT) begin
                        ev_valid = 1'b1;
                        ev_ext   = 1'b1;
                    end
                end
                ST_SKIP: begin
                    nxt_skip = skip_cnt - 1'b1;
                    if (skip_cnt <= 3'd1) begin
                        nxt_state = ST_IDLE;
                        nxt_skip  = '0;
                    end
                end
                default: nxt_state = ST_IDLE;
            endcase
        end
    end

    ps2_keymap u_keymap (
        .ext  (ev_ext),
        .code (byte_reg),
        .map  (km)
    );

    assign mods = {alt_l | alt_r, ctrl_l | ctrl_r, shift_l | shift_r};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            skip_cnt  <= '0;
            key_evt   <= 1'b0;
            reset_key <= '0;
            alt_l     <= 1'b0;
            alt_r     <= 1'b0;
            ctrl_l    <= 1'b0;
            ctrl_r    <= 1'b0;
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                keystate[r] <= '0;
            end
        end else begin
            state    <= nxt_state;
            skip_cnt <= nxt_skip;
            key_evt  <= 1'b0;
            if (overrun) begin
                for (int r = 0; r < ROWS; r++) begin
                    keystate[r] <= '0;
                end
            end
            if (ev_valid) begin
                if (km.hit && (int'(km.row) < ROWS)) begin
                    keystate[km.row][km.col] <= ev_make;
                    key_evt <= (keystate[km.row][km.col] != ev_make);
                end
                if (byte_reg == MC_ALT)    begin if (ev_ext) alt_r  <= ev_make; else alt_l  <= ev_make; end
                if (byte_reg == MC_CTRL)   begin if (ev_ext) ctrl_r <= ev_make; else ctrl_l <= ev_make; end
                if (byte_reg == MC_LSHIFT) shift_l <= ev_make;
                if (byte_reg == MC_RSHIFT) shift_r <= ev_make;
                // Hotkey code uses modifier state from before this event
                if (byte_reg == KC_F11 && !ev_ext) begin
                    reset_key <= ev_make ? {mods[2], mods[0], |mods} : 3'b000;
                end
            end
        end
    end

    always_comb begin
        odata = '0;
        for (int r = 0; r < SCAN_ROWS; r++) begin
            if (addr[r]) odata = odata | keystate[r];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_matrix.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_kbd_matrix
// Description : Directed self-checking bench for ps2_kbd_matrix.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_matrix;

    localparam int H = 8;   // PS/2 clock half period in clk cycles

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] addr = 8'h00;
    logic [7:0] odata;
    logic [2:0] mods;
    logic [2:0] reset_key;
    logic       frame_err;
    logic       key_evt;

    int checks = 0;
    int failures = 0;
    int evt_cnt = 0;
    int err_cnt = 0;

    ps2_kbd_matrix dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .addr      (addr),
        .odata     (odata),
        .mods      (mods),
        .reset_key (reset_key),
        .frame_err (frame_err),
        .key_evt   (key_evt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_evt)   evt_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Send the first n bits of an 11-bit frame, LSB (start) first
    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ps2_dat = fr[i];
            repeat (H) @(posedge clk);
            #1 ps2_clk = 1'b0;
            repeat (H) @(posedge clk);
            #1 ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_bits({1'b1, ~^b, b, 1'b0}, 11);
        repeat (10) @(posedge clk);
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        @(posedge clk); #1 addr = a;
        @(negedge clk); d = odata;
    endtask

    initial begin
        logic [7:0] d;
        int e0;

        repeat (3) @(posedge clk);
        addr = 8'hFF;
        @(negedge clk);
        chk("rst_odata", odata, 0);
        chk("rst_mods", mods, 0);
        chk("rst_reset_key", reset_key, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_key_evt", key_evt, 0);
        #1 reset_n = 1'b1;
        repeat (5) @(posedge clk);

        // A make, typematic repeat, break
        send(8'h1C);
        rd(8'h10, d); chk("a_make_row4", d, 8'h02);
        chk("a_make_evt", evt_cnt, 1);
        rd(8'h00, d); chk("addr0_zero", d, 8'h00);
        send(8'h1C);
        chk("a_repeat_no_evt", evt_cnt, 1);
        send(8'hF0); send(8'h1C);
        rd(8'h10, d); chk("a_break_row4", d, 8'h00);
        chk("a_break_evt", evt_cnt, 2);

        // Bad parity, bad stop, then a good byte
        send_bits({1'b1, ^8'h1C, 8'h1C, 1'b0}, 11); repeat (10) @(posedge clk);
        send_bits({1'b0, ~^8'h1C, 8'h1C, 1'b0}, 11); repeat (10) @(posedge clk);
        chk("bad_frames_err", err_cnt, 2);
        rd(8'hFF, d); chk("bad_frames_nokey", d, 8'h00);
        send(8'h1C);
        rd(8'h10, d); chk("after_err_a", d, 8'h02);
        send(8'hF0); send(8'h1C);

        // Partial frame and watchdog
        send_bits({1'b1, ~^8'h5A, 8'h5A, 1'b0}, 5);
        repeat (19900) @(posedge clk);
        chk("wd_not_early", err_cnt, 2);
        for (int i = 0; i < 400 && err_cnt == 2; i++) @(posedge clk);
        chk("wd_timeout_err", err_cnt, 3);
        send(8'h5A);
        rd(8'h01, d); chk("wd_recover_enter", d, 8'h04);
        send(8'hF0); send(8'h5A);
        chk("enter_evts", evt_cnt, 6);

        // Fake shift around extended up arrow
        send(8'hE0); send(8'h12); send(8'hE0); send(8'h75);
        chk("fake_shift_mods", mods, 3'b000);
        rd(8'h01, d); chk("ext_up_make", d, 8'h20);
        send(8'hE0); send(8'hF0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h12);
        rd(8'h01, d); chk("ext_up_break", d, 8'h00);
        chk("fake_shift_mods2", mods, 3'b000);

        // F11 hotkey
        send(8'h12); send(8'h11);
        chk("shift_alt_mods", mods, 3'b101);
        send(8'h78);
        chk("hotkey_all", reset_key, 3'b111);
        send(8'hF0); send(8'h78);
        chk("hotkey_release", reset_key, 3'b000);
        send(8'hF0); send(8'h12); send(8'hF0); send(8'h11);
        chk("mods_released", mods, 3'b000);
        send(8'h14);
        chk("ctrl_mods", mods, 3'b010);
        send(8'h78);
        chk("hotkey_ctrl", reset_key, 3'b001);
        send(8'hF0); send(8'h78); send(8'hF0); send(8'h14);
        chk("mod_evts", evt_cnt, 14);

        // Pause sequence is swallowed
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        chk("pause_mods", mods, 3'b000);
        chk("pause_no_evt", evt_cnt, 14);
        rd(8'hFF, d); chk("pause_no_key", d, 8'h00);
        send(8'h1C);
        rd(8'h10, d); chk("post_pause_a", d, 8'h02);

        // Overrun clears held keys
        send(8'h15);
        rd(8'h50, d); chk("held_a_q", d, 8'h02);
        send(8'hFF);
        rd(8'hFF, d); chk("overrun_clear", d, 8'h00);

        // Reset in the middle of a frame
        send(8'h12); send(8'h1C);
        rd(8'h10, d); chk("pre_reset_a", d, 8'h02);
        send_bits({1'b1, ~^8'h2B, 8'h2B, 1'b0}, 4);
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        chk("async_rst_odata", odata, 0);
        chk("async_rst_mods", mods, 0);
        chk("async_rst_reset_key", reset_key, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (5) @(posedge clk);
        send(8'h1C);
        rd(8'h10, d); chk("post_reset_a", d, 8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
